sti_so_receiver: RTL and testbench

//   Downstream stage of the STI serializer: deserializes the so_data/so_valid bit stream into words.

---
 rtl/sti_pkg.sv | 29 ++
 rtl/sti_rx_fifo.sv | 66 ++++++
 rtl/sti_so_receiver.sv | 153 +++++++++++++++
 tb/tb_sti_so_receiver.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sti_pkg.sv
// Shared constants and helpers for the STI serial-out receiver.
package sti_pkg;

  localparam int unsigned FRAME_W   = 32;
  localparam int unsigned BIT_CNT_W = 6;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRecv  = 2'd1;
  localparam logic [1:0] StCheck = 2'd2;

  localparam logic [1:0] LEN_8  = 2'd0;
  localparam logic [1:0] LEN_16 = 2'd1;
  localparam logic [1:0] LEN_24 = 2'd2;
  localparam logic [1:0] LEN_32 = 2'd3;

  function automatic logic frame_ok(input logic [BIT_CNT_W-1:0] cnt);
    return (cnt == 6'd8) || (cnt == 6'd16) || (cnt == 6'd24) || (cnt == 6'd32);
  endfunction

  function automatic logic [1:0] len_code(input logic [BIT_CNT_W-1:0] cnt);
    case (cnt)
      6'd8:    return LEN_8;
      6'd16:   return LEN_16;
      6'd24:   return LEN_24;
      default: return LEN_32;
    endcase
  endfunction

endpackage

// File: rtl/sti_rx_fifo.sv
// First-word-fall-through FIFO for received {len, data} entries.
module sti_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 34,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a push while full is still taken.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/sti_so_receiver.sv
// Deserializes so_valid bursts into {len, data} words queued for a valid/ready consumer.
// Define SO_RX_STATS_EN to add the frame_cnt/err_cnt statistics outputs.
module sti_so_receiver
  import sti_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               so_data,
  input  logic               so_valid,
  input  logic               oem_finish,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [FRAME_W-1:0] out_data,
  output logic [1:0]         out_len,
  output logic               frame_err,
  output logic               ovf,
  output logic               rx_done
`ifdef SO_RX_STATS_EN
  ,
  output logic [7:0]         frame_cnt,
  output logic [7:0]         err_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [1:0]           state_q, state_d;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 frame_err_q, frame_err_d;
  logic                 ovf_q, ovf_d;
  logic                 pend_fin_q, pend_fin_d;
  logic                 rx_done_q, rx_done_d;

  logic                 push_req, pop, drop, fifo_full, fifo_empty;
  logic [FRAME_W+1:0]   head;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    frame_err_d = 1'b0;
    push_req    = 1'b0;
    case (state_q)
      StIdle: begin
        if (so_valid) begin
          shreg_d   = {{(FRAME_W-1){1'b0}}, so_data};
          bit_cnt_d = 6'd1;
          state_d   = StRecv;
        end
      end
      StRecv: begin
        if (so_valid) begin
          shreg_d   = {shreg_q[FRAME_W-2:0], so_data};
          bit_cnt_d = (bit_cnt_q == '1) ? bit_cnt_q : bit_cnt_q + 1'b1;
        end else begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        push_req    = frame_ok(bit_cnt_q);
        frame_err_d = ~frame_ok(bit_cnt_q);
        if (so_valid) begin
          shreg_d   = {{(FRAME_W-1){1'b0}}, so_data};
          bit_cnt_d = 6'd1;
          state_d   = StRecv;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pop        = out_valid & out_ready;
  assign drop       = push_req & fifo_full & ~pop;
  assign ovf_d      = ovf_q | drop;
  assign pend_fin_d = pend_fin_q | oem_finish;
  assign rx_done_d  = rx_done_q | (pend_fin_q & (state_q == StIdle) & fifo_empty);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
      pend_fin_q  <= 1'b0;
      rx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
      pend_fin_q  <= pend_fin_d;
      rx_done_q   <= rx_done_d;
    end
  end

  sti_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FRAME_W + 2),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_req),
    .wdata_i ({len_code(bit_cnt_q), shreg_q}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = head[FRAME_W-1:0];
  assign out_len   = head[FRAME_W+1:FRAME_W];
  assign frame_err = frame_err_q;
  assign ovf       = ovf_q;
  assign rx_done   = rx_done_q;

`ifdef SO_RX_STATS_EN
  logic [7:0] frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
  logic [8:0] err_sum;

  // Both error sources can in principle coincide, so the increment is 0..2.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (push_req && !drop && frame_cnt_q != 8'hFF) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
    err_sum   = {1'b0, err_cnt_q} + {8'd0, frame_err_q} + {8'd0, drop};
    err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_sti_so_receiver.sv
// Scoreboard bench for sti_so_receiver: expected words queued at send time, checked on pop.
module tb_sti_so_receiver;

  logic        clk, reset, so_data, so_valid, oem_finish, out_ready;
  logic        out_valid, frame_err, ovf, rx_done;
  logic [31:0] out_data;
  logic [1:0]  out_len;
`ifdef SO_RX_STATS_EN
  logic [7:0]  frame_cnt, err_cnt;
`endif

  logic [33:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  sti_so_receiver #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .so_data    (so_data),
    .so_valid   (so_valid),
    .oem_finish (oem_finish),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_len    (out_len),
    .frame_err  (frame_err),
    .ovf        (ovf),
    .rx_done    (rx_done)
`ifdef SO_RX_STATS_EN
    ,
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves so_valid high; the caller drops it. Returns at the start of cycle N+1.
  task automatic send_frame(input logic [63:0] data, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      so_valid = 1'b1;
      so_data  = data[i];
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; so_data = 0; so_valid = 0; oem_finish = 0; out_ready = 0;
    #3;
    n_checks++;
    if ({out_valid, out_data, out_len, frame_err, ovf, rx_done} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0",
               {out_valid, out_data, out_len, frame_err, ovf, rx_done});
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if ({out_valid, frame_err, ovf, rx_done} !== 4'd0) begin
      n_fail++;
      $display("FAIL post_reset_flags: got %b required 0000",
               {out_valid, frame_err, ovf, rx_done});
    end
  endtask

  task automatic test_latency();
    logic [33:0] e;
    out_ready = 1'b1;
    send_frame(64'hA5, 8);
    exp_q.push_back({2'd0, 32'h0000_00A5});
    so_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_n1: out_valid %b required 0", out_valid); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_n2: out_valid %b required 0", out_valid); end
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if ({out_valid, out_len, out_data} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL lat_n3: got v=%b len=%0d data=%h required v=1 len=%0d data=%h",
               out_valid, out_len, out_data, e[33:32], e[31:0]);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_n4: out_valid %b required 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [33:0] e;
    int          cyc;
    out_ready = 1'b0;
    send_frame(64'hDEAD_BEEF, 32);
    exp_q.push_back({2'd3, 32'hDEAD_BEEF});
    so_valid = 1'b0;
    tick();
    send_frame(64'h1234, 16);
    exp_q.push_back({2'd1, 32'h0000_1234});
    so_valid = 1'b0;
    tick(); tick(); tick();
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({out_len, out_data} !== e) begin
          n_fail++;
          $display("FAIL b2b_word: got len=%0d data=%h required len=%0d data=%h",
                   out_len, out_data, e[33:32], e[31:0]);
        end
      end
      tick();
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_timeout: %0d words outstanding required 0", exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: out_valid %b required 0", out_valid); end
  endtask

  task automatic test_frame_err(input int nbits);
    int pulses, seen_valid;
    out_ready  = 1'b1;
    pulses     = 0;
    seen_valid = 0;
    send_frame(64'h1_5A5A_5A5A, nbits);
    so_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pulses     += int'(frame_err);
      seen_valid += int'(out_valid);
      tick();
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL frame_err_%0d: pulse cycles %0d required 1", nbits, pulses);
    end
    n_checks++;
    if (seen_valid != 0) begin
      n_fail++;
      $display("FAIL frame_err_fifo_%0d: out_valid cycles %0d required 0", nbits, seen_valid);
    end
  endtask

  task automatic test_overflow();
    logic [33:0] e;
    int          cyc;
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send_frame(64'(k), 8);
      if (k <= 4) exp_q.push_back({2'd0, 32'(k)});
      so_valid = 1'b0;
      tick(); tick();
    end
    tick(); tick();
    n_checks++;
    if ({ovf, out_valid, out_data} !== {2'b11, 32'h1}) begin
      n_fail++;
      $display("FAIL ovf_full: got ovf=%b v=%b data=%h required ovf=1 v=1 data=00000001",
               ovf, out_valid, out_data);
    end
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({out_len, out_data} !== e) begin
          n_fail++;
          $display("FAIL ovf_drain: got len=%0d data=%h required len=%0d data=%h",
                   out_len, out_data, e[33:32], e[31:0]);
        end
      end
      tick();
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ovf_timeout: %0d words outstanding required 0", exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if ({out_valid, ovf} !== 2'b01) begin
      n_fail++;
      $display("FAIL ovf_after_drain: got v=%b ovf=%b required v=0 ovf=1", out_valid, ovf);
    end
  endtask

  task automatic test_rx_done();
    logic [33:0] e;
    int          cyc;
    out_ready = 1'b0;
    send_frame(64'h11, 8); exp_q.push_back({2'd0, 32'h11}); so_valid = 1'b0; tick(); tick();
    send_frame(64'h22, 8); exp_q.push_back({2'd0, 32'h22}); so_valid = 1'b0;
    tick(); tick(); tick();
    oem_finish = 1'b1;
    tick();
    oem_finish = 1'b0;
    for (int p = 0; p < 2; p++) begin
      tick(); tick(); tick();
      n_checks++;
      if (rx_done !== 1'b0) begin
        n_fail++;
        $display("FAIL rx_done_early_%0d: got %b required 0", p, rx_done);
      end
      e = exp_q.pop_front();
      n_checks++;
      if ({out_valid, out_len, out_data} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL rx_done_word_%0d: got v=%b data=%h required v=1 data=%h",
                 p, out_valid, out_data, e[31:0]);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    cyc = 0;
    while (rx_done !== 1'b1 && cyc < 10) begin
      tick();
      cyc++;
    end
    n_checks++;
    if ({rx_done, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL rx_done_set: got rx_done=%b v=%b required rx_done=1 v=0", rx_done, out_valid);
    end
  endtask

  task automatic test_reset_mid_frame();
    int pulses;
    out_ready = 1'b0;
    send_frame(64'h77, 8);
    so_valid = 1'b0;
    tick(); tick(); tick();
    send_frame(64'hBEEF >> 8, 8);
    reset    = 1'b1;
    so_valid = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_data, out_len, frame_err, ovf, rx_done} !== 38'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h required 0",
               {out_valid, out_data, out_len, frame_err, ovf, rx_done});
    end
    tick();
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      pulses += int'(frame_err) + int'(out_valid);
      tick();
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL mid_reset_quiet: frame_err/out_valid cycles %0d required 0", pulses);
    end
  endtask

  task automatic test_after_reset();
    logic [33:0] e;
    int          cyc;
    out_ready = 1'b1;
    send_frame(64'h3C, 8);
    exp_q.push_back({2'd0, 32'h3C});
    so_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 10) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({out_len, out_data} !== e) begin
          n_fail++;
          $display("FAIL after_reset_word: got len=%0d data=%h required len=%0d data=%h",
                   out_len, out_data, e[33:32], e[31:0]);
        end
      end
      tick();
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL after_reset_timeout: %0d words outstanding required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_frame_err(12);
    test_frame_err(33);
    test_overflow();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    test_rx_done();
    test_reset_mid_frame();
    test_after_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
